// File: rtl/riscv_pkg.sv
// Shared types for the instruction fetch slice: the prefetch buffer entry and the fetch FSM states.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            err;
   } fetch_entry_t;

   typedef enum logic {
      FS_RUN,
      FS_HALT
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with registered storage and a flush that empties it in one cycle.
module riscv_sync_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rstf,
   input  logic                     flush,
   input  logic                     push,
   input  T                         push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output T                         head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   T              mem_q [DEPTH];

   // NOTE: every signal gets its default before any branch, so no path can infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstf) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers and count alone define which slots are live.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= push_data;
   end

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: credit-limited sequential iBus requests, in-order response buffering,
// and redirect handling that flushes the buffer and drops stale in-flight responses.
module riscv_fetch
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rstf,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        iBus_cmd_valid,
   input  logic        iBus_cmd_ready,
   output logic [31:0] iBus_cmd_payload_pc,
   input  logic        iBus_rsp_ready,
   input  logic        iBus_rsp_err,
   input  logic [31:0] iBus_rsp_instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_data,
   output logic        instr_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  resp_pc_q, resp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   fetch_state_e state_q, state_d;

   logic          fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  fifo_head, push_entry;
   logic [CW:0]   in_use;
   logic          issue_allowed, cmd_fire;

   // Buffered entries plus in-flight requests never exceed DEPTH, so a response always has a slot.
   assign in_use        = {1'b0, fifo_count} + {1'b0, outstanding_q};
   assign issue_allowed = (state_q == FS_RUN) && (in_use < (CW+1)'(DEPTH));
   assign iBus_cmd_valid      = rstf && issue_allowed && !redirect_valid;
   assign iBus_cmd_payload_pc = fetch_pc_q;
   assign cmd_fire            = iBus_cmd_valid && iBus_cmd_ready;

   assign push_entry = '{pc: resp_pc_q, instr: iBus_rsp_instr, err: iBus_rsp_err};

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      state_d       = state_q;
      discard_d     = discard_q;
      outstanding_d = outstanding_q + CW'(cmd_fire) - CW'(iBus_rsp_ready);
      fifo_flush    = 1'b0;
      fifo_push     = 1'b0;
      fifo_pop      = 1'b0;
      if (redirect_valid) begin
         // Everything still on the bus after this cycle belongs to the old path.
         fifo_flush = 1'b1;
         fetch_pc_d = word_align(redirect_pc);
         resp_pc_d  = word_align(redirect_pc);
         state_d    = FS_RUN;
         discard_d  = outstanding_d;
      end else begin
         fifo_pop = instr_valid && instr_ready;
         if (cmd_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (iBus_rsp_ready) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CW'(1);
            end else begin
               fifo_push = !fifo_full;
               resp_pc_d = resp_pc_q + 32'd4;
               if (iBus_rsp_err) state_d = FS_HALT;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstf) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         state_q       <= FS_RUN;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         state_q       <= state_d;
      end
   end

   riscv_sync_fifo #(
      .T     (fetch_entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstf      (rstf),
      .flush     (fifo_flush),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   // Outputs are forced to zero when empty so unwritten storage never leaks to decode.
   assign instr_valid = !fifo_empty;
   assign instr_pc    = instr_valid ? fifo_head.pc    : '0;
   assign instr_data  = instr_valid ? fifo_head.instr : '0;
   assign instr_err   = instr_valid && fifo_head.err;

endmodule

// File: tb/tb_riscv_fetch.sv
// Self-checking bench for riscv_fetch: directed vector table, hand-written corner sequences,
// and a random phase compared against a queue-based reference model.
module tb_riscv_fetch;
   import riscv_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstf, redirect_valid, iBus_cmd_ready, iBus_rsp_ready, iBus_rsp_err, instr_ready;
   logic [31:0] redirect_pc, iBus_rsp_instr;
   logic        iBus_cmd_valid, instr_valid, instr_err;
   logic [31:0] iBus_cmd_payload_pc, instr_pc, instr_data;

   always #5 clk = ~clk;

   riscv_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk                 (clk),
      .rstf                (rstf),
      .redirect_valid      (redirect_valid),
      .redirect_pc         (redirect_pc),
      .iBus_cmd_valid      (iBus_cmd_valid),
      .iBus_cmd_ready      (iBus_cmd_ready),
      .iBus_cmd_payload_pc (iBus_cmd_payload_pc),
      .iBus_rsp_ready      (iBus_rsp_ready),
      .iBus_rsp_err        (iBus_rsp_err),
      .iBus_rsp_instr      (iBus_rsp_instr),
      .instr_valid         (instr_valid),
      .instr_ready         (instr_ready),
      .instr_pc            (instr_pc),
      .instr_data          (instr_data),
      .instr_err           (instr_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: requests on the bus in order, each tagged stale once a redirect orphans it.
   typedef struct { logic [31:0] pc; bit stale; } req_t;
   req_t         inflight[$];
   fetch_entry_t m_fifo[$];
   logic [31:0]  m_fetch_pc = 32'h0;
   bit           m_halt = 1'b0;

   // Values sampled mid-cycle by the last step, for directed checks.
   bit          s_cv, s_iv, s_ierr;
   logic [31:0] s_cpc, s_ipc, s_idata;
   int          dut_fires;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return (pc * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic bit m_cmd_valid(input bit rn, input bit redir);
      return rn && !redir && !m_halt && (m_fifo.size() + inflight.size() < DEPTH);
   endfunction

   task automatic step(input bit rn, input bit redir, input logic [31:0] rpc, input bit cready,
                       input bit rsp_in, input bit err_in, input bit iready, input bit chk);
      bit           rsp, exp_cv;
      fetch_entry_t head;
      req_t         r;
      @(negedge clk);
      rsp            = rsp_in && rn && (inflight.size() > 0);
      rstf           = rn;
      redirect_valid = redir;
      redirect_pc    = rpc;
      iBus_cmd_ready = cready;
      iBus_rsp_ready = rsp;
      iBus_rsp_err   = rsp && err_in;
      iBus_rsp_instr = rsp ? instr_of(inflight[0].pc) : 32'hDEAD_BEEF;
      instr_ready    = iready;
      #1;
      exp_cv = m_cmd_valid(rn, redir);
      head   = (m_fifo.size() > 0) ? m_fifo[0] : '0;
      s_cv = iBus_cmd_valid; s_cpc = iBus_cmd_payload_pc;
      s_iv = instr_valid; s_ipc = instr_pc; s_idata = instr_data; s_ierr = instr_err;
      if (iBus_cmd_valid && cready) dut_fires++;
      if (chk) begin
         check("cmd_valid", iBus_cmd_valid, exp_cv);
         if (exp_cv) check("cmd_pc", iBus_cmd_payload_pc, m_fetch_pc);
         check("instr_valid", instr_valid, m_fifo.size() > 0);
         check("instr_pc", instr_pc, head.pc);
         check("instr_data", instr_data, head.instr);
         check("instr_err", instr_err, head.err);
      end
      @(posedge clk);
      if (!rn) begin
         inflight.delete();
         m_fifo.delete();
         m_fetch_pc = 32'h0;
         m_halt     = 1'b0;
      end else if (redir) begin
         m_fifo.delete();
         if (rsp) r = inflight.pop_front();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         m_fetch_pc = {rpc[31:2], 2'b00};
         m_halt     = 1'b0;
      end else begin
         if (m_fifo.size() > 0 && iready) void'(m_fifo.pop_front());
         if (rsp) begin
            r = inflight.pop_front();
            if (!r.stale) begin
               m_fifo.push_back('{pc: r.pc, instr: instr_of(r.pc), err: err_in});
               if (err_in) m_halt = 1'b1;
            end
         end
         if (exp_cv && cready) begin
            inflight.push_back('{pc: m_fetch_pc, stale: 1'b0});
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
   endtask

   typedef struct {
      bit rn, redir; logic [31:0] rpc; bit cready, rsp, iready;
      bit e_cv; logic [31:0] e_cpc; bit e_iv; logic [31:0] e_ipc;
   } vec_t;

   vec_t vecs[18];

   initial begin
      bit          found, saw_err, rerr;
      logic [31:0] got_pc;

      rstf = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; iBus_cmd_ready = 1'b0;
      iBus_rsp_ready = 1'b0; iBus_rsp_err = 1'b0; iBus_rsp_instr = '0; instr_ready = 1'b0;
      dut_fires = 0;

      //          rn redir rpc          crdy rsp irdy  e_cv e_cpc          e_iv e_ipc
      vecs[0]  = '{0, 0, 32'h0,         1, 0, 1,   0, 32'h0,         0, 32'h0};
      vecs[1]  = '{1, 0, 32'h0,         1, 0, 1,   1, 32'h0,         0, 32'h0};
      vecs[2]  = '{1, 0, 32'h0,         1, 1, 1,   1, 32'h4,         0, 32'h0};
      vecs[3]  = '{1, 0, 32'h0,         1, 1, 1,   1, 32'h8,         1, 32'h0};
      vecs[4]  = '{1, 0, 32'h0,         1, 1, 1,   1, 32'hC,         1, 32'h4};
      vecs[5]  = '{1, 0, 32'h0,         1, 1, 1,   1, 32'h10,        1, 32'h8};
      vecs[6]  = '{0, 0, 32'h0,         1, 0, 1,   0, 32'h0,         1, 32'hC};
      vecs[7]  = '{1, 0, 32'h0,         0, 0, 1,   1, 32'h0,         0, 32'h0};
      vecs[8]  = '{1, 0, 32'h0,         1, 0, 1,   1, 32'h0,         0, 32'h0};
      vecs[9]  = '{1, 0, 32'h0,         1, 0, 1,   1, 32'h4,         0, 32'h0};
      vecs[10] = '{1, 0, 32'h0,         1, 0, 1,   1, 32'h8,         0, 32'h0};
      vecs[11] = '{1, 1, 32'h103,       1, 0, 1,   0, 32'h0,         0, 32'h0};
      vecs[12] = '{1, 0, 32'h0,         1, 1, 1,   1, 32'h100,       0, 32'h0};
      vecs[13] = '{1, 0, 32'h0,         1, 1, 1,   1, 32'h104,       0, 32'h0};
      vecs[14] = '{1, 0, 32'h0,         1, 1, 1,   1, 32'h108,       0, 32'h0};
      vecs[15] = '{1, 0, 32'h0,         1, 1, 1,   1, 32'h10C,       0, 32'h0};
      vecs[16] = '{1, 0, 32'h0,         1, 1, 1,   0, 32'h0,         1, 32'h100};
      vecs[17] = '{1, 0, 32'h0,         1, 1, 1,   1, 32'h110,       1, 32'h104};

      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Fill, steady stream, mid-burst reset, redirect with three requests in flight.
      for (int i = 0; i < 18; i++) begin
         step(vecs[i].rn, vecs[i].redir, vecs[i].rpc, vecs[i].cready, vecs[i].rsp, 1'b0,
              vecs[i].iready, 1'b1);
         check($sformatf("vec%0d_cmd_valid", i), s_cv, vecs[i].e_cv);
         if (vecs[i].e_cv) check($sformatf("vec%0d_cmd_pc", i), s_cpc, vecs[i].e_cpc);
         check($sformatf("vec%0d_instr_valid", i), s_iv, vecs[i].e_iv);
         if (vecs[i].e_iv) begin
            check($sformatf("vec%0d_instr_pc", i), s_ipc, vecs[i].e_ipc);
            check($sformatf("vec%0d_instr_data", i), s_idata, instr_of(vecs[i].e_ipc));
         end
      end

      // Backpressure from decode: exactly DEPTH requests, then resume at 0x10 as entries drain.
      step(0, 0, 0, 0, 0, 0, 0, 1);
      dut_fires = 0;
      for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 1, 0, 0, 1);
      check("bp_fires", dut_fires, 4);
      check("bp_stalled", s_cv, 1'b0);
      found = 1'b0; got_pc = 32'hFFFF_FFFF;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1, 0, 0, 1, 1, 0, 1, 1);
         if (s_cv) begin found = 1'b1; got_pc = s_cpc; end
      end
      check("bp_resume_pc", got_pc, 32'h10);

      // Redirect coinciding with the response for 0x4 while 0x4 and 0x8 are outstanding.
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 1, 0, 0, 1, 1);
      step(1, 0, 0, 1, 1, 0, 1, 1);
      step(1, 0, 0, 1, 0, 0, 1, 1);
      step(1, 1, 32'h200, 1, 1, 0, 1, 1);
      found = 1'b0; got_pc = 32'hFFFF_FFFF;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1, 0, 0, 1, 1, 0, 1, 1);
         if (s_iv) begin found = 1'b1; got_pc = s_ipc; end
      end
      check("redir_rsp_first_pc", got_pc, 32'h200);

      // Error response on 0x8 halts issue; redirect restarts at 0x40.
      step(0, 0, 0, 0, 0, 0, 0, 1);
      saw_err = 1'b0;
      for (int i = 0; i < 12; i++) begin
         rerr = (inflight.size() > 0) && (inflight[0].pc == 32'h8);
         step(1, 0, 0, 1, 1, rerr, 1, 1);
         if (s_iv && s_ipc == 32'h8 && s_ierr) saw_err = 1'b1;
      end
      check("err_delivered", saw_err, 1'b1);
      check("err_halted", s_cv, 1'b0);
      step(1, 1, 32'h40, 1, 0, 0, 1, 1);
      step(1, 0, 0, 1, 0, 0, 1, 1);
      check("err_resume_valid", s_cv, 1'b1);
      check("err_resume_pc", s_cpc, 32'h40);

      // Address wrap, then reset in the middle of a burst.
      step(1, 1, 32'hFFFF_FFFE, 1, 1, 0, 1, 1);
      step(1, 0, 0, 1, 1, 0, 1, 1);
      check("wrap_first_pc", s_cpc, 32'hFFFF_FFFC);
      step(1, 0, 0, 1, 1, 0, 1, 1);
      check("wrap_next_pc", s_cpc, 32'h0);
      step(1, 0, 0, 1, 1, 0, 0, 1);
      step(1, 0, 0, 1, 1, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 1, 1);
      check("rst_mid_instr_valid", s_iv, 1'b0);
      check("rst_mid_cmd_pc", s_cpc, 32'h0);

      // Random traffic against the reference model.
      for (int i = 0; i < 3000; i++) begin
         bit          rn, redir, crdy, rsp, err, irdy;
         logic [31:0] rpc;
         rn    = ($urandom_range(299) != 0);
         redir = ($urandom_range(29) == 0);
         rpc   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
         crdy  = ($urandom_range(9) < 7);
         rsp   = ($urandom_range(9) < 6);
         err   = ($urandom_range(39) == 0);
         irdy  = ($urandom_range(9) < 6);
         step(rn, redir, rpc, crdy, rsp, err, irdy, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
